fb_blitter: RTL
===============

# fb_blitter

Frame-buffer writer for the 320x240, 12-bit video buffer: on command it copies a rectangular sprite from a source region of the shared single-port SRAM into the visible buffer at a destination (x, y), clipping at the buffer edges. It drives the same SRAM port (addr/en/we/data) that the VGA address-generation logic reads. Arbitration with the display side, e.g. running only during vertical blanking, is the job of the instantiating module.

## Interface
Parameters:
- VBUF_W, 320: buffer width in pixels.
- VBUF_H, 240: buffer height in pixels.
- ADDR_WIDTH, 18: SRAM address width.
- DATA_WIDTH, 12: pixel width, RGB 4:4:4.
- KEY_COLOR, 12'h0F0: transparent colour, used only when chroma-keying is compiled in.

Ports:
- clk, input, 1: system clock. Only one clock.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle command strobe. Sampled only in IDLE.
- src_base, input, ADDR_WIDTH: source address of sprite pixel (0,0). Source is row-major with stride src_w.
- src_w, input, 9: sprite width.
- src_h, input, 9: sprite height.
- dst_x, input, 9: destination column of the sprite's top-left pixel.
- dst_y, input, 9: destination row of the sprite's top-left pixel.
- busy, output, 1: high while a copy is in progress.
- done, output, 1: one-cycle completion pulse.
- mem_addr, output, ADDR_WIDTH: SRAM address.
- mem_en, output, 1: SRAM enable.
- mem_we, output, 1: SRAM write enable.
- mem_wdata, output, DATA_WIDTH: SRAM write data.
- mem_rdata, input, DATA_WIDTH: SRAM read data. Valid in the cycle after the address is presented.

## Operation
- Command latch:
  - In IDLE, start=1 latches all command inputs and clears the row and col counters (9 bit each).
  - If src_w==0 or src_h==0, the block skips to DONE.
- FSM per pixel: IDLE -> RD -> DAT -> WR. After WR:
  - next pixel -> RD;
  - last pixel (row==src_h-1 and col==src_w-1) -> DONE.
  - DONE -> IDLE, unconditionally.
- RD:
  - mem_addr = src_base + row*src_w + col, truncated mod 2^ADDR_WIDTH.
  - mem_en=1, mem_we=0.
- DAT: mem_en=0. mem_rdata is registered into pix_q.
- WR:
  - dx = dst_x+col and dy = dst_y+row, both 10 bit.
  - mem_addr = dy*VBUF_W + dx.
  - mem_wdata = pix_q.
  - mem_en = mem_we = in_bounds, where in_bounds = (dx < VBUF_W) && (dy < VBUF_H).
  - Out-of-bounds pixels still consume their 3 cycles but perform no write.
- Counter advance: col increments after each WR; on col==src_w-1, col goes to 0 and row increments. No other wrap exists.
- start is ignored outside IDLE, including in DONE. Command inputs are don't-care after the latch.
- Idle outputs: mem_en=0, mem_we=0, and mem_addr, mem_wdata hold their last values.
- Reset, including mid-copy: immediate return to IDLE with busy=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 and counters at 0. A partially written sprite is not undone.

## Timing
- start is high in cycle 0, so the first RD is in cycle 1.
- Each pixel takes exactly 3 cycles.
- For N = src_w*src_h pixels, the last WR is in cycle 3N.
- busy=1 in cycles 1..3N. busy is a registered output and is 0 in IDLE and DONE.
- done=1 only in cycle 3N+1; the block is back in IDLE at cycle 3N+2, where start is accepted again.
- Zero-size command: busy stays 0 and done pulses in cycle 1.
- At most one SRAM access per cycle. A write never overlaps a read.

## Configuration
- FB_BLIT_CHROMA_KEY_EN defined: a WR-cycle write is additionally suppressed when pix_q == KEY_COLOR. The cycle is still spent.
- FB_BLIT_CHROMA_KEY_EN undefined: every in-bounds pixel is written. KEY_COLOR is unused.

## Test plan
- 2x2 copy, src_base=76800, dst=(10,20), source 12'h111, 12'h222, 12'h333, 12'h444 -> writes to addresses 6410, 6411, 6730, 6731 in that order, with the matching data; done in cycle 13.
- Right/bottom clipping, 4x2 sprite at dst=(318,239) -> writes only to 76798 and 76799; no writes for row 1; done in cycle 25.
- Macro defined, one pixel equals 12'h0F0 in a 3x1 copy -> 2 writes, the keyed address is untouched. Macro undefined -> 3 writes.
- src_w=0 -> no mem_en at all, busy never rises, done pulses in cycle 1.
- start re-asserted in cycles 2..5 of a 2x1 copy -> ignored: exactly 2 writes and a single done pulse in cycle 7.
- reset_n low in cycle 4 of a 2x2 copy, so after the first write in cycle 3 -> outputs go to reset values asynchronously and there are no further writes; a new start after release runs a full copy.

Source files
------------

// File: rtl/fb_blitter.sv
// fb_blitter: rectangular sprite copy into the 320x240x12 frame buffer.
//
// Copies a src_w x src_h sprite, stored row-major at src_base in the shared
// single-port SRAM, to the visible buffer at (dst_x, dst_y). Pixels falling
// outside the buffer are skipped but still take their three cycles
// (read, data, write). One SRAM access per cycle at most.
//
// Optional feature: define FB_BLIT_CHROMA_KEY_EN to suppress writes of
// pixels equal to KEY_COLOR (transparent colour).
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start                one-cycle command strobe, sampled only when idle
//   src_base/src_w/src_h sprite source address and size
//   dst_x/dst_y          destination of the sprite's top-left pixel
//   busy, done           copy in progress / one-cycle completion pulse
//   mem_addr/en/we/wdata SRAM request port (registered)
//   mem_rdata            SRAM read data, valid the cycle after the address
module fb_blitter #(
   parameter int unsigned           VBUF_W     = 320,
   parameter int unsigned           VBUF_H     = 240,
   parameter int unsigned           ADDR_WIDTH = 18,
   parameter int unsigned           DATA_WIDTH = 12,
   parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 'h0F0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_base,
   input  logic [8:0]            src_w,
   input  logic [8:0]            src_h,
   input  logic [8:0]            dst_x,
   input  logic [8:0]            dst_y,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [2:0] {StIdle, StRd, StDat, StWr, StDone} state_e;

   localparam logic [9:0] VbufW10 = 10'(VBUF_W);
   localparam logic [9:0] VbufH10 = 10'(VBUF_H);

   state_e                r_state;
   logic                  r_busy;
   logic                  r_done;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  r_mem_en;
   logic                  r_mem_we;
   // Loaded from mem_rdata in DAT: this register is the pixel latch (pix_q).
   logic [DATA_WIDTH-1:0] r_mem_wdata;

   logic [ADDR_WIDTH-1:0] r_src_base;
   logic [8:0]            r_src_w;
   logic [8:0]            r_src_h;
   logic [8:0]            r_dst_x;
   logic [8:0]            r_dst_y;
   logic [8:0]            r_row;
   logic [8:0]            r_col;

   logic                  w_last_col;
   logic                  w_last_pix;
   logic [8:0]            w_col_nxt;
   logic [8:0]            w_row_nxt;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic [9:0]            w_dx;
   logic [9:0]            w_dy;
   logic                  w_in_bounds;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic                  w_wr_en;

   assign w_last_col = (r_col == r_src_w - 9'd1);
   assign w_last_pix = w_last_col && (r_row == r_src_h - 9'd1);
   assign w_col_nxt  = w_last_col ? 9'd0 : r_col + 9'd1;
   assign w_row_nxt  = w_last_col ? r_row + 9'd1 : r_row;

   // Source address of the pixel following the current one; all terms are
   // ADDR_WIDTH wide so the sum wraps modulo 2^ADDR_WIDTH.
   assign w_rd_addr = r_src_base
                    + ADDR_WIDTH'(w_row_nxt) * ADDR_WIDTH'(r_src_w)
                    + ADDR_WIDTH'(w_col_nxt);

   assign w_dx        = 10'(r_dst_x) + 10'(r_col);
   assign w_dy        = 10'(r_dst_y) + 10'(r_row);
   assign w_in_bounds = (w_dx < VbufW10) && (w_dy < VbufH10);
   assign w_wr_addr   = ADDR_WIDTH'(w_dy) * ADDR_WIDTH'(VBUF_W) + ADDR_WIDTH'(w_dx);

`ifdef FB_BLIT_CHROMA_KEY_EN
   // Decided in DAT from mem_rdata, i.e. the value pix_q holds during WR.
   assign w_wr_en = w_in_bounds && (mem_rdata != KEY_COLOR);
`else
   logic w_unused_key;
   assign w_unused_key = ^KEY_COLOR;
   assign w_wr_en      = w_in_bounds;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
         r_src_base  <= '0;
         r_src_w     <= '0;
         r_src_h     <= '0;
         r_dst_x     <= '0;
         r_dst_y     <= '0;
         r_row       <= '0;
         r_col       <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               r_done   <= 1'b0;
               if (start) begin
                  r_src_base <= src_base;
                  r_src_w    <= src_w;
                  r_src_h    <= src_h;
                  r_dst_x    <= dst_x;
                  r_dst_y    <= dst_y;
                  r_row      <= '0;
                  r_col      <= '0;
                  if (src_w == 9'd0 || src_h == 9'd0) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end else begin
                     // First pixel is (0,0), so its source address is src_base.
                     r_state    <= StRd;
                     r_busy     <= 1'b1;
                     r_mem_addr <= src_base;
                     r_mem_en   <= 1'b1;
                  end
               end
            end
            StRd: begin
               r_state  <= StDat;
               r_mem_en <= 1'b0;
            end
            StDat: begin
               r_state     <= StWr;
               r_mem_addr  <= w_wr_addr;
               r_mem_wdata <= mem_rdata;
               r_mem_en    <= w_wr_en;
               r_mem_we    <= w_wr_en;
            end
            StWr: begin
               r_col <= w_col_nxt;
               r_row <= w_row_nxt;
               r_mem_we <= 1'b0;
               if (w_last_pix) begin
                  r_state  <= StDone;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_mem_en <= 1'b0;
               end else begin
                  r_state    <= StRd;
                  r_mem_addr <= w_rd_addr;
                  r_mem_en   <= 1'b1;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_done  <= 1'b0;
            end
            default: begin
               r_state  <= StIdle;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign mem_addr  = r_mem_addr;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;

endmodule
